fp_multiplier_param: RTL and testbench

Parametrised, iterative IEEE 754 floating-point multiplier. It succeeds the fixed single-precision multiplier in the ALU and adds configurable exponent/mantissa widths, two rounding modes, IEEE special-value handling and exception flags. It sits in the ALU behind the same start/valid/busy handshake, so the datapath can issue to either unit. The mantissa product uses a radix-2 shift-add core, one bit per cycle.

---
 rtl/fp_multiplier_param.sv | 215 +++++++++++++++++++++
 tb/tb_fp_multiplier_param.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/fp_multiplier_param.sv
// fp_multiplier_param
//   Iterative IEEE 754 multiplier. The exponent and fraction widths are
//   parameters. It supports round-to-nearest-even and round-toward-zero,
//   handles the special values, and raises exception flags. Subnormal
//   inputs are treated as zero, and underflowing results are flushed to
//   signed zero. The significand product comes from a radix-2 shift-add
//   loop that handles one multiplier bit per cycle.
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous, active-low reset
//   start     request; sampled only while busy=0
//   rs1, rs2  operands, latched with start
//   rnd_mode  0 = RNE, 1 = RTZ; latched with start
//   result    product; held from one valid pulse until the next
//   flags     {invalid, overflow, underflow, inexact}; updated with result
//   valid     one-cycle pulse when result and flags are new
//   busy      high while an operation is in flight
module fp_multiplier_param #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [EXP_W+MAN_W:0]     rs1,
    input  logic [EXP_W+MAN_W:0]     rs2,
    input  logic                     rnd_mode,
    output logic [EXP_W+MAN_W:0]     result,
    output logic [3:0]               flags,
    output logic                     valid,
    output logic                     busy
);
    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int SIG  = MAN_W + 1;
    localparam int PW   = 2 * SIG;
    localparam int XW   = EXP_W + 2;
    localparam int BIAS = (1 << (EXP_W - 1)) - 1;
    localparam int CW   = $clog2(SIG + 1);

    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, UNPACK, MUL, NORM, ROUND, DONE} state_t;
    state_t state, state_nx;

    logic [W-1:0]     a_q, b_q;
    logic             rm_q;
    logic             sign_q;
    logic [XW-1:0]    exp_q;       // two's complement biased exponent
    logic [SIG-1:0]   mcand_q;
    logic [PW-1:0]    prod_q;      // {partial sum, remaining multiplier bits}
    logic [CW-1:0]    cnt_q;
    logic             sticky_q;    // bit lost by the normalising shift
    logic             special_q;
    logic [W-1:0]     spec_res_q;
    logic [3:0]       spec_flg_q;
    logic [MAN_W-1:0] frac_q;
    logic             inexact_q;

    // ---------------- unpack / special-value classification ----------------
    logic [EXP_W-1:0] e1, e2;
    logic [MAN_W-1:0] f1, f2;
    logic             z1, z2, i1, i2, n1, n2, sgn, special;
    logic [W-1:0]     spec_res;
    logic [3:0]       spec_flg;
    logic [XW-1:0]    exp_sum;

    assign e1  = a_q[W-2:MAN_W];
    assign e2  = b_q[W-2:MAN_W];
    assign f1  = a_q[MAN_W-1:0];
    assign f2  = b_q[MAN_W-1:0];
    assign sgn = a_q[W-1] ^ b_q[W-1];
    // An exponent field of zero covers both zero and subnormals (flushed).
    assign z1  = (e1 == '0);
    assign z2  = (e2 == '0);
    assign i1  = (&e1) && (f1 == '0);
    assign i2  = (&e2) && (f2 == '0);
    assign n1  = (&e1) && (f1 != '0);
    assign n2  = (&e2) && (f2 != '0);
    assign special = z1 | z2 | i1 | i2 | n1 | n2;
    assign exp_sum = {2'b00, e1} + {2'b00, e2} - XW'(BIAS);

    always_comb begin
        spec_res = '0;
        spec_flg = '0;
        if (n1 | n2) begin
            spec_res = QNAN;
        end else if ((z1 & i2) | (i1 & z2)) begin
            spec_res = QNAN;
            spec_flg = 4'b1000;
        end else if (i1 | i2) begin
            spec_res = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (z1 | z2) begin
            spec_res = {sgn, {(W-1){1'b0}}};
        end
    end

    // ---------------- shift-add step ----------------
    logic [SIG:0] add_sum;
    assign add_sum = {1'b0, prod_q[PW-1:SIG]} + (prod_q[0] ? {1'b0, mcand_q} : '0);

    // ---------------- rounding ----------------
    // After NORM the leading one sits at bit PW-2.
    logic         lsb, grd, stk, rup;
    logic [MAN_W:0] man_r;
    assign lsb   = prod_q[SIG-1];
    assign grd   = prod_q[SIG-2];
    assign stk   = (|prod_q[SIG-3:0]) | sticky_q;
    assign rup   = !rm_q && grd && (stk || lsb);
    assign man_r = {1'b0, prod_q[PW-3:SIG-1]} + (MAN_W+1)'(rup);

    logic ovf, unf;
    assign ovf = !exp_q[XW-1] && (exp_q[XW-2:0] >= (XW-1)'((1 << EXP_W) - 1));
    assign unf = exp_q[XW-1] || (exp_q == '0);

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = UNPACK;
            UNPACK:  state_nx = special ? DONE : MUL;
            MUL:     if (cnt_q == CW'(MAN_W - 1)) state_nx = NORM;
            NORM:    state_nx = ROUND;
            ROUND:   state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q        <= '0;
            b_q        <= '0;
            rm_q       <= 1'b0;
            sign_q     <= 1'b0;
            exp_q      <= '0;
            mcand_q    <= '0;
            prod_q     <= '0;
            cnt_q      <= '0;
            sticky_q   <= 1'b0;
            special_q  <= 1'b0;
            spec_res_q <= '0;
            spec_flg_q <= '0;
            frac_q     <= '0;
            inexact_q  <= 1'b0;
            result     <= '0;
            flags      <= '0;
            valid      <= 1'b0;
            busy       <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    a_q  <= rs1;
                    b_q  <= rs2;
                    rm_q <= rnd_mode;
                    busy <= 1'b1;
                end
                UNPACK: begin
                    sign_q     <= sgn;
                    exp_q      <= exp_sum;
                    mcand_q    <= {1'b1, f1};
                    special_q  <= special;
                    spec_res_q <= spec_res;
                    spec_flg_q <= spec_flg;
                    cnt_q      <= '0;
                    sticky_q   <= 1'b0;
                    // UNPACK does the first partial product, using multiplier
                    // bit 0. MUL then needs only MAN_W more cycles.
                    prod_q     <= {(f2[0] ? {1'b0, 1'b1, f1} : {(SIG+1){1'b0}}),
                                   1'b1, f2[MAN_W-1:1]};
                end
                MUL: begin
                    prod_q <= {add_sum, prod_q[SIG-1:1]};
                    cnt_q  <= cnt_q + CW'(1);
                end
                NORM: if (prod_q[PW-1]) begin
                    prod_q   <= prod_q >> 1;
                    sticky_q <= prod_q[0];
                    exp_q    <= exp_q + XW'(1);
                end
                ROUND: begin
                    frac_q    <= man_r[MAN_W-1:0];
                    exp_q     <= man_r[MAN_W] ? exp_q + XW'(1) : exp_q;
                    inexact_q <= grd | stk;
                end
                DONE: begin
                    busy  <= 1'b0;
                    valid <= 1'b1;
                    if (special_q) begin
                        result <= spec_res_q;
                        flags  <= spec_flg_q;
                    end else if (ovf) begin
                        result <= rm_q ? {sign_q, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}}
                                       : {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                        flags  <= 4'b0101;
                    end else if (unf) begin
                        result <= {sign_q, {(W-1){1'b0}}};
                        flags  <= 4'b0011;
                    end else begin
                        result <= {sign_q, exp_q[EXP_W-1:0], frac_q};
                        flags  <= {3'b000, inexact_q};
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_multiplier_param.sv
module tb_fp_multiplier_param;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int LAT_N = MAN_W + 4;
    localparam int LAT_S = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [31:0] rs1 = '0, rs2 = '0;
    logic        rnd_mode = 1'b0;
    logic [31:0] result;
    logic [3:0]  flags;
    logic        valid, busy;

    fp_multiplier_param #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
        .clk(clk), .rst(rst), .start(start), .rs1(rs1), .rs2(rs2),
        .rnd_mode(rnd_mode), .result(result), .flags(flags),
        .valid(valid), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] a, b;
        logic        rm;
        logic [31:0] res;
        logic [3:0]  flg;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flg;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: every valid pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        exp_t e;
        if (rst && valid) begin
            if (sbq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_valid: got result %h with no request outstanding", result);
            end else begin
                e = sbq.pop_front();
                check("result", result, e.res);
                check("flags", {28'd0, flags}, {28'd0, e.flg});
                check("latency", 32'(cyc - e.acc), 32'(e.lat));
            end
        end
    end

    // The caller must be at a negedge. Returns shortly after the accept edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic rm,
                         input logic [31:0] res, input logic [3:0] flg, input int lat);
        exp_t e;
        int   t = 0;
        while (busy && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (busy) begin
            n_checks++;
            n_fail++;
            $display("FAIL issue_timeout: busy still %b after %0d cycles, expected 0", busy, t);
        end
        start = 1'b1; rs1 = a; rs2 = b; rnd_mode = rm;
        @(posedge clk);
        #1;
        start = 1'b0;
        e.res = res; e.flg = flg; e.lat = lat; e.acc = cyc;
        sbq.push_back(e);
    endtask

    task automatic wait_drain();
        int t = 0;
        while (sbq.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (sbq.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", sbq.size());
            sbq.delete();
        end
    endtask

    vec_t vecs[13];
    int   cnt;

    initial begin
        vecs[0]  = '{32'hBFC00000, 32'h40400000, 1'b0, 32'hC0900000, 4'b0000, LAT_N};
        vecs[1]  = '{32'h3FC00001, 32'h3FC00001, 1'b0, 32'h40100002, 4'b0001, LAT_N};
        vecs[2]  = '{32'h3FC00001, 32'h3FC00001, 1'b1, 32'h40100001, 4'b0001, LAT_N};
        vecs[3]  = '{32'h7F000000, 32'h40000000, 1'b0, 32'h7F800000, 4'b0101, LAT_N};
        vecs[4]  = '{32'h7F000000, 32'h40000000, 1'b1, 32'h7F7FFFFF, 4'b0101, LAT_N};
        vecs[5]  = '{32'h00000000, 32'h7F800000, 1'b0, 32'h7FC00000, 4'b1000, LAT_S};
        vecs[6]  = '{32'hFF800000, 32'h40000000, 1'b0, 32'hFF800000, 4'b0000, LAT_S};
        vecs[7]  = '{32'h00000001, 32'h40000000, 1'b0, 32'h00000000, 4'b0000, LAT_S};
        vecs[8]  = '{32'h00800000, 32'h3F000000, 1'b0, 32'h00000000, 4'b0011, LAT_N};
        vecs[9]  = '{32'h80800000, 32'h3F000000, 1'b0, 32'h80000000, 4'b0011, LAT_N};
        vecs[10] = '{32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0000, LAT_S};
        vecs[11] = '{32'h3F800000, 32'h3F800000, 1'b0, 32'h3F800000, 4'b0000, LAT_N};
        vecs[12] = '{32'h3F800001, 32'h3F800001, 1'b0, 32'h3F800002, 4'b0001, LAT_N};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_result", result, 32'h0);
        check("rst_flags", {28'd0, flags}, 32'h0);
        check("rst_valid", {31'd0, valid}, 32'h0);
        check("rst_busy", {31'd0, busy}, 32'h0);
        rst = 1'b1;
        @(negedge clk);

        // Table vectors
        for (int i = 0; i < 13; i++) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].rm, vecs[i].res, vecs[i].flg, vecs[i].lat);
            wait_drain();
        end

        // Busy duration, then back-to-back issue in the valid cycle
        @(negedge clk);
        issue(32'hBFC00000, 32'h40400000, 1'b0, 32'hC0900000, 4'b0000, LAT_N);
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (valid) break;
            if (busy) cnt++;
        end
        check("busy_cycles", 32'(cnt), 32'(LAT_N));
        check("busy_in_valid", {31'd0, busy}, 32'h0);
        issue(32'h3F800000, 32'h40000000, 1'b0, 32'h40000000, 4'b0000, LAT_N);
        wait_drain();

        // A start while busy is ignored
        @(negedge clk);
        issue(32'h3F800000, 32'h40000000, 1'b0, 32'h40000000, 4'b0000, LAT_N);
        repeat (5) @(negedge clk);
        start = 1'b1; rs1 = 32'h40400000; rs2 = 32'h40400000;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_drain();
        repeat (5) @(negedge clk);

        // Reset mid-operation discards the in-flight request
        issue(32'hBFC00000, 32'h40400000, 1'b0, 32'hC0900000, 4'b0000, LAT_N);
        repeat (10) @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_busy", {31'd0, busy}, 32'h0);
        check("midrst_valid", {31'd0, valid}, 32'h0);
        check("midrst_result", result, 32'h0);
        check("midrst_flags", {28'd0, flags}, 32'h0);
        sbq.delete();
        @(negedge clk);
        rst = 1'b1;
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (valid) cnt++;
        end
        check("no_valid_after_rst", 32'(cnt), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
